// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU stripe loader and the write-select mux array.
package mcu_pkg;

   // Default pixel width used by the loader and the mux array
   localparam int MCU_BITS_IMAGEN = 8;

   // Loader FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Mux select codes: three pixel slots of the packed word, plus the
   // convolver path that only the mux array's other master drives
   localparam logic [1:0] SEL_PIX0 = 2'b00;
   localparam logic [1:0] SEL_PIX1 = 2'b01;
   localparam logic [1:0] SEL_PIX2 = 2'b10;
   localparam logic [1:0] SEL_CONV = 2'b11;

endpackage

// File: rtl/mcu_stripe_loader.sv
// Stripe loader: takes packed 3-pixel host words and emits one pixel write
// per cycle into an (N+2)-column set of column memories, column by column.
//
// Handshake: a word is accepted on a rising clock edge where i_Valid and
// o_Ready are both 1. o_Ready depends only on registered state (it is high
// exactly in WAIT), so the host may look at o_Ready before deciding i_Valid
// without creating a loop. i_Valid while o_Ready is low is ignored.
module mcu_stripe_loader
   import mcu_pkg::*;
#(
   parameter int N           = 2,
   parameter int BITS_IMAGEN = MCU_BITS_IMAGEN,
   parameter int BITS_ADDR   = 10
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_Start,
   input  logic [BITS_ADDR-1:0]     i_ImgHeight,
   input  logic                     i_Valid,
   input  logic [3*BITS_IMAGEN-1:0] i_Data,
   output logic                     o_Ready,
   output logic [3*BITS_IMAGEN-1:0] o_Data,
   output logic [1:0]               o_Sel,
   output logic [N+1:0]             o_WrEn,
   output logic [BITS_ADDR-1:0]     o_WrAddr,
   output logic                     o_Done,
   output state_e                   o_State
);

   localparam int                   CW       = $clog2(N + 2);
   localparam logic [CW-1:0]        LAST_COL = CW'(N + 1);
   localparam logic [CW-1:0]        ONE_COL  = CW'(1);
   localparam logic [BITS_ADDR-1:0] ONE_ROW  = BITS_ADDR'(1);

   state_e                   state_q;
   logic [CW-1:0]            col_q;
   logic [BITS_ADDR-1:0]     row_q;
   logic [1:0]               slot_q;
   logic [BITS_ADDR-1:0]     h_q;
   logic [3*BITS_IMAGEN-1:0] data_q;

   logic                     last_row;
   logic                     emit;

   // h_q is never zero while writing, so h_q-1 is the last valid row
   assign last_row = (row_q == (h_q - ONE_ROW));
   assign emit     = (state_q == ST_EMIT);

   assign o_Ready  = (state_q == ST_WAIT);
   assign o_Sel    = emit ? slot_q : SEL_PIX0;
   assign o_WrEn   = emit ? ({{(N+1){1'b0}}, 1'b1} << col_q) : '0;
   assign o_WrAddr = emit ? row_q : '0;
   assign o_Done   = (state_q == ST_DONE);
   assign o_Data   = data_q;
   assign o_State  = state_q;

   // Stripe sequencing: column/row/slot counters and the held host word
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         slot_q  <= '0;
         h_q     <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_Start) begin
                  if (i_ImgHeight != '0) begin
                     h_q     <= i_ImgHeight;
                     col_q   <= '0;
                     row_q   <= '0;
                     slot_q  <= '0;
                     state_q <= ST_WAIT;
                  end else begin
                     // Empty stripe: report completion without any writes
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_WAIT: begin
               if (i_Valid) begin
                  data_q  <= i_Data;
                  slot_q  <= '0;
                  state_q <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (last_row) begin
                  // Column full: leftover slots of this word are dropped
                  row_q <= '0;
                  if (col_q == LAST_COL) begin
                     state_q <= ST_DONE;
                  end else begin
                     col_q   <= col_q + ONE_COL;
                     state_q <= ST_WAIT;
                  end
               end else if (slot_q == SEL_PIX2) begin
                  row_q   <= row_q + ONE_ROW;
                  state_q <= ST_WAIT;
               end else begin
                  row_q  <= row_q + ONE_ROW;
                  slot_q <= slot_q + 2'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_stripe_loader.sv
// Directed bench for mcu_stripe_loader (N=2, 8-bit pixels, 10-bit rows).
module tb_mcu_stripe_loader;
   import mcu_pkg::*;

   localparam int N  = 2;
   localparam int BI = 8;
   localparam int BA = 10;
   localparam int EW = (N + 2) + BA + 2 + BI;

   // ---------------- clock / reset ----------------
   logic            i_CLK       = 1'b0;
   logic            i_RST       = 1'b1;
   logic            i_Start     = 1'b0;
   logic [BA-1:0]   i_ImgHeight = '0;
   logic            i_Valid     = 1'b0;
   logic [3*BI-1:0] i_Data      = '0;
   logic            o_Ready;
   logic [3*BI-1:0] o_Data;
   logic [1:0]      o_Sel;
   logic [N+1:0]    o_WrEn;
   logic [BA-1:0]   o_WrAddr;
   logic            o_Done;
   state_e          o_State;

   always #5 i_CLK = ~i_CLK;

   mcu_stripe_loader #(.N(N), .BITS_IMAGEN(BI), .BITS_ADDR(BA)) dut (
      .i_CLK       (i_CLK),
      .i_RST       (i_RST),
      .i_Start     (i_Start),
      .i_ImgHeight (i_ImgHeight),
      .i_Valid     (i_Valid),
      .i_Data      (i_Data),
      .o_Ready     (o_Ready),
      .o_Data      (o_Data),
      .o_Sel       (o_Sel),
      .o_WrEn      (o_WrEn),
      .o_WrAddr    (o_WrAddr),
      .o_Done      (o_Done),
      .o_State     (o_State)
   );

   int tests = 0;
   int fails = 0;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] act_q[$];
   int            cyc         = 0;
   int            last_wr_cyc = 0;
   int            done_cyc    = 0;
   int            done_cnt    = 0;
   logic [7:0]    mon_pix;

   // Record every memory write as {wren, addr, sel, pixel selected by the mux}
   always @(negedge i_CLK) begin
      cyc = cyc + 1;
      if (o_WrEn != '0) begin
         mon_pix = 8'(o_Data >> ({3'b000, o_Sel} << 3));
         act_q.push_back({o_WrEn, o_WrAddr, o_Sel, mon_pix});
         last_wr_cyc = cyc;
      end
      if (o_Done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   // Host word k carries pixels 3k+1, 3k+2, 3k+3 (lowest row in the low byte)
   function automatic logic [3*BI-1:0] word_of(input int k);
      logic [7:0] a, b, c;
      a = 8'(3 * k + 1);
      b = 8'(3 * k + 2);
      c = 8'(3 * k + 3);
      return {c, b, a};
   endfunction

   // Expected writes of a full stripe of height h
   function automatic void build_exp(input int h);
      int           wpc;
      int           idx;
      logic [N+1:0] en;
      exp_q.delete();
      wpc = (h + 2) / 3;
      for (int c = 0; c < N + 2; c++) begin
         for (int r = 0; r < h; r++) begin
            idx   = c * wpc + r / 3;
            en    = '0;
            en[c] = 1'b1;
            exp_q.push_back({en, BA'(r), 2'(r % 3), 8'(3 * idx + (r % 3) + 1)});
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic start_stripe(input logic [BA-1:0] h);
      i_Start     = 1'b1;
      i_ImgHeight = h;
      @(negedge i_CLK);
      i_Start     = 1'b0;
      i_ImgHeight = ~h;
   endtask

   task automatic drive_words(input int n, output logic ok);
      int k;
      int g;
      k = 0;
      g = 0;
      i_Valid = 1'b1;
      while (k < n && g < 8000) begin
         i_Data = word_of(k);
         if (o_Ready) k++;
         g++;
         @(negedge i_CLK);
      end
      i_Valid = 1'b0;
      ok = (k == n);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      #1 i_RST = 1'b0;
      #1;
      tests++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", o_Ready); end
      tests++; if (o_Data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", o_Data); end
      tests++; if (o_Sel !== 2'b00) begin fails++; $display("FAIL reset_sel: got %b want 00", o_Sel); end
      tests++; if (o_WrEn !== '0) begin fails++; $display("FAIL reset_wren: got %b want 0", o_WrEn); end
      tests++; if (o_WrAddr !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", o_WrAddr); end
      tests++; if (o_Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", o_Done); end
      tests++; if (o_State !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want 0", o_State); end
      repeat (2) @(negedge i_CLK);
      i_RST = 1'b1;
      repeat (2) @(negedge i_CLK);
      tests++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b want 0", o_Ready); end
   endtask

   task automatic test_stripe(input int h, input string name);
      logic ok;
      int   n;
      act_q.delete();
      done_cnt = 0;
      build_exp(h);
      n = (N + 2) * ((h + 2) / 3);
      start_stripe(BA'(h));
      drive_words(n, ok);
      tests++; if (!ok) begin fails++; $display("FAIL %s feed: timeout got %0d want 1", name, ok); end
      repeat (8) @(negedge i_CLK);
      tests++;
      if (act_q.size() != exp_q.size()) begin
         fails++; $display("FAIL %s write_count: got %0d want %0d", name, act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (act_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL %s write[%0d]: got %h want %h", name, i, act_q[i], exp_q[i]);
         end
      end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
      tests++;
      if (done_cyc != last_wr_cyc + 1) begin
         fails++; $display("FAIL %s done_timing: got %0d want %0d", name, done_cyc, last_wr_cyc + 1);
      end
      tests++; if (o_State !== ST_IDLE) begin fails++; $display("FAIL %s end_state: got %0d want 0", name, o_State); end
   endtask

   task automatic test_stream_h6;
      int k;
      int j;
      act_q.delete();
      done_cnt = 0;
      build_exp(6);
      start_stripe(BA'(6));
      k = 0;
      j = 0;
      i_Valid = 1'b1;
      while (k < 8 && j < 100) begin
         i_Data = word_of(k);
         tests++;
         if (o_Ready !== (j % 4 == 0)) begin
            fails++; $display("FAIL stream_ready[%0d]: got %b want %b", j, o_Ready, (j % 4 == 0));
         end
         if (o_Ready) k++;
         j++;
         @(negedge i_CLK);
      end
      i_Valid = 1'b0;
      tests++; if (k != 8) begin fails++; $display("FAIL stream_feed: got %0d want 8", k); end
      repeat (8) @(negedge i_CLK);
      tests++;
      if (act_q.size() != exp_q.size()) begin
         fails++; $display("FAIL stream write_count: got %0d want %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (act_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL stream write[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
         end
      end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL stream done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_zero_height;
      act_q.delete();
      i_Start     = 1'b1;
      i_ImgHeight = '0;
      @(negedge i_CLK);
      i_Start = 1'b0;
      tests++; if (o_Done !== 1'b1) begin fails++; $display("FAIL h0_done: got %b want 1", o_Done); end
      tests++; if (o_WrEn !== '0) begin fails++; $display("FAIL h0_wren: got %b want 0", o_WrEn); end
      tests++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL h0_ready: got %b want 0", o_Ready); end
      @(negedge i_CLK);
      tests++; if (o_Done !== 1'b0) begin fails++; $display("FAIL h0_done_pulse: got %b want 0", o_Done); end
      tests++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL h0_idle_ready: got %b want 0", o_Ready); end
      repeat (3) @(negedge i_CLK);
      tests++; if (act_q.size() != 0) begin fails++; $display("FAIL h0_writes: got %0d want 0", act_q.size()); end
   endtask

   task automatic test_reset_mid_emit;
      start_stripe(BA'(3));
      i_Valid = 1'b1;
      i_Data  = 24'hAABBCC;
      @(negedge i_CLK);
      i_Valid = 1'b0;
      tests++; if (o_WrEn !== 4'b0001) begin fails++; $display("FAIL mid_first_wren: got %b want 0001", o_WrEn); end
      @(negedge i_CLK);
      tests++; if (o_Sel !== 2'b01) begin fails++; $display("FAIL mid_second_sel: got %b want 01", o_Sel); end
      tests++; if (o_WrAddr !== BA'(1)) begin fails++; $display("FAIL mid_second_addr: got %0d want 1", o_WrAddr); end
      #2 i_RST = 1'b0;
      #1;
      tests++; if (o_WrEn !== '0) begin fails++; $display("FAIL mid_rst_wren: got %b want 0", o_WrEn); end
      tests++; if (o_Sel !== 2'b00) begin fails++; $display("FAIL mid_rst_sel: got %b want 00", o_Sel); end
      tests++; if (o_WrAddr !== '0) begin fails++; $display("FAIL mid_rst_addr: got %0d want 0", o_WrAddr); end
      tests++; if (o_Data !== '0) begin fails++; $display("FAIL mid_rst_data: got %h want 0", o_Data); end
      tests++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b want 0", o_Ready); end
      tests++; if (o_State !== ST_IDLE) begin fails++; $display("FAIL mid_rst_state: got %0d want 0", o_State); end
      @(negedge i_CLK);
      i_RST = 1'b1;
      @(negedge i_CLK);
   endtask

   task automatic test_start_while_busy;
      logic ok;
      logic pulsed;
      act_q.delete();
      done_cnt = 0;
      pulsed   = 1'b0;
      build_exp(3);
      start_stripe(BA'(3));
      fork
         drive_words(4, ok);
         begin
            for (int g = 0; g < 20; g++) begin
               @(negedge i_CLK);
               if (o_WrEn != '0) begin
                  i_Start     = 1'b1;
                  i_ImgHeight = BA'(7);
                  pulsed      = 1'b1;
                  @(negedge i_CLK);
                  i_Start = 1'b0;
                  break;
               end
            end
         end
      join
      tests++; if (!ok) begin fails++; $display("FAIL busy feed: timeout got %0d want 1", ok); end
      tests++; if (!pulsed) begin fails++; $display("FAIL busy pulse: got %0d want 1", pulsed); end
      repeat (8) @(negedge i_CLK);
      tests++;
      if (act_q.size() != exp_q.size()) begin
         fails++; $display("FAIL busy write_count: got %0d want %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (act_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL busy write[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
         end
      end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL busy done_count: got %0d want 1", done_cnt); end
      tests++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL busy end_ready: got %b want 0", o_Ready); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset;
      test_stripe(3, "h3");
      test_stripe(4, "h4");
      test_stream_h6;
      test_zero_height;
      test_reset_mid_emit;
      test_stripe(3, "after_reset");
      test_start_while_busy;
      test_stripe(1, "h1");
      test_stripe(1023, "hmax");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
